// File: rtl/k6502_pkg.sv
// k6502_pkg
// Shared types and the opcode predecode function for the k6502 timing logic.
//   tstate_t     : 3-bit T-state (1..7); T1 is the opcode fetch cycle.
//   addr_mode_t  : addressing-mode classification of an opcode.
//   predecode_t  : {mode, rmw, store, cycles, len} result of predecode().
//   predecode()  : maps an opcode byte to its addressing mode, memory RMW and
//                  store flags, base cycle count (2..7) and length (1..3).
//                  Undefined opcodes decode as a 2-cycle, 1-byte NOP.
package k6502_pkg;

    typedef logic [2:0] tstate_t;

    localparam tstate_t T1         = 3'd1;
    localparam tstate_t T2         = 3'd2;
    localparam logic [2:0] MAX_CYC = 3'd7;

    typedef enum logic [3:0] {
        AM_IMPLIED,
        AM_ACC,
        AM_IMM,
        AM_ZP,
        AM_ZPX,
        AM_ABS,
        AM_ABSX,
        AM_INDX,
        AM_INDY,
        AM_REL,
        AM_IND,
        AM_STACK
    } addr_mode_t;

    typedef struct packed {
        addr_mode_t mode;
        logic       rmw;
        logic       store;
        logic [2:0] cycles;
        logic [1:0] len;
    } predecode_t;

    // The opcode is split as aaa_bbb_cc. cc selects the instruction group,
    // bbb the addressing mode within the group, aaa the operation.
    // abs,Y and zp,Y share the absx/zpx classification: their timing is identical.
    function automatic predecode_t predecode(input logic [7:0] op);
        predecode_t r;
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] c;
        logic       rmw_op;
        logic       st_op;
        a      = op[7:5];
        b      = op[4:2];
        c      = op[1:0];
        rmw_op = 1'b0;
        st_op  = 1'b0;
        r      = '{mode: AM_IMPLIED, rmw: 1'b0, store: 1'b0, cycles: 3'd2, len: 2'd1};
        case (c)
            2'b01: begin
                // ALU group; aaa=100 is STA
                st_op = (a == 3'b100);
                case (b)
                    3'd0: r = '{AM_INDX, 1'b0, st_op, 3'd6, 2'd2};
                    3'd1: r = '{AM_ZP,   1'b0, st_op, 3'd3, 2'd2};
                    3'd2: if (!st_op) r = '{AM_IMM, 1'b0, 1'b0, 3'd2, 2'd2};
                    3'd3: r = '{AM_ABS,  1'b0, st_op, 3'd4, 2'd3};
                    3'd4: r = '{AM_INDY, 1'b0, st_op, st_op ? 3'd6 : 3'd5, 2'd2};
                    3'd5: r = '{AM_ZPX,  1'b0, st_op, 3'd4, 2'd2};
                    default: r = '{AM_ABSX, 1'b0, st_op, st_op ? 3'd5 : 3'd4, 2'd3};
                endcase
            end
            2'b10: begin
                // Shift/inc/dec group; aaa=100 STX, aaa=101 LDX, the rest RMW
                rmw_op = (a != 3'b100) && (a != 3'b101);
                st_op  = (a == 3'b100);
                case (b)
                    3'd0: if (a == 3'b101) r = '{AM_IMM, 1'b0, 1'b0, 3'd2, 2'd2};
                    3'd1: r = '{AM_ZP,  rmw_op, st_op, rmw_op ? 3'd5 : 3'd3, 2'd2};
                    3'd2: if (a[2] == 1'b0) r = '{AM_ACC, 1'b0, 1'b0, 3'd2, 2'd1};
                    3'd3: r = '{AM_ABS, rmw_op, st_op, rmw_op ? 3'd6 : 3'd4, 2'd3};
                    3'd5: r = '{AM_ZPX, rmw_op, st_op, rmw_op ? 3'd6 : 3'd4, 2'd2};
                    3'd7: if (a != 3'b100)
                              r = '{AM_ABSX, rmw_op, 1'b0, rmw_op ? 3'd7 : 3'd4, 2'd3};
                    default: ;
                endcase
            end
            2'b00: begin
                case (b)
                    3'd0: begin
                        case (a)
                            3'd0: r = '{AM_STACK, 1'b0, 1'b0, 3'd7, 2'd2};  // BRK
                            3'd1: r = '{AM_ABS,   1'b0, 1'b0, 3'd6, 2'd3};  // JSR
                            3'd2,
                            3'd3: r = '{AM_STACK, 1'b0, 1'b0, 3'd6, 2'd1};  // RTI, RTS
                            3'd5,
                            3'd6,
                            3'd7: r = '{AM_IMM,   1'b0, 1'b0, 3'd2, 2'd2};  // LDY/CPY/CPX #
                            default: ;
                        endcase
                    end
                    3'd1: if (a == 3'd1 || a >= 3'd4)
                              r = '{AM_ZP, 1'b0, (a == 3'd4), 3'd3, 2'd2};
                    3'd2: begin
                        // PHP/PHA push in 3, PLP/PLA pull in 4; the rest are implied
                        if (a == 3'd0 || a == 3'd2)
                            r = '{AM_STACK, 1'b0, 1'b0, 3'd3, 2'd1};
                        else if (a == 3'd1 || a == 3'd3)
                            r = '{AM_STACK, 1'b0, 1'b0, 3'd4, 2'd1};
                    end
                    3'd3: begin
                        if (a == 3'd2)
                            r = '{AM_ABS, 1'b0, 1'b0, 3'd3, 2'd3};          // JMP abs
                        else if (a == 3'd3)
                            r = '{AM_IND, 1'b0, 1'b0, 3'd5, 2'd3};          // JMP ind
                        else if (a != 3'd0)
                            r = '{AM_ABS, 1'b0, (a == 3'd4), 3'd4, 2'd3};
                    end
                    3'd4: r = '{AM_REL, 1'b0, 1'b0, 3'd2, 2'd2};
                    3'd5: if (a == 3'd4 || a == 3'd5)
                              r = '{AM_ZPX, 1'b0, (a == 3'd4), 3'd4, 2'd2};
                    3'd7: if (a == 3'd5)
                              r = '{AM_ABSX, 1'b0, 1'b0, 3'd4, 2'd3};       // LDY abs,X
                    default: ;
                endcase
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/k6502_predecode.sv
// k6502_predecode
// Combinational opcode classifier.
//   op          in   8  opcode byte
//   base_cycles out  3  base cycle count, 2..7
//   length      out  2  instruction length in bytes, 1..3
module k6502_predecode
    import k6502_pkg::*;
(
    input  logic [7:0] op,
    output logic [2:0] base_cycles,
    output logic [1:0] length
);

    predecode_t info;
    logic       unused_fields;

    assign info        = predecode(op);
    assign base_cycles = info.cycles;
    assign length      = info.len;

    // Mode and RMW/store flags belong to the control decoder, not to timing.
    assign unused_fields = ^{info.mode, info.rmw, info.store};

endmodule

// File: rtl/k6502_timing.sv
// k6502_timing
// Instruction register, predecode and T-state generator for the k6502 core.
//   ph0          in   1  core clock, rising edge
//   reset        in   1  synchronous active-high reset (overrides rdy)
//   d            in   8  data bus, opcode byte during T1
//   rdy          in   1  cycle enable; low holds all state
//   extra_cycle  in   1  datapath request for one inserted cycle (T2 onward)
//   ir           out  8  instruction register
//   t_state      out  3  current cycle 1..7
//   sync         out  1  t_state == 1
//   cycles_total out  3  base plus inserted cycles, 2..7
//   opcode_len   out  2  instruction length 1..3
//   last_cycle   out  1  final cycle of the instruction (never T1)
module k6502_timing
    import k6502_pkg::*;
#(
    parameter logic [7:0] IR_RESET = 8'h00
) (
    input  logic       ph0,
    input  logic       reset,
    input  logic [7:0] d,
    input  logic       rdy,
    input  logic       extra_cycle,
    output logic [7:0] ir,
    output logic [2:0] t_state,
    output logic       sync,
    output logic [2:0] cycles_total,
    output logic [1:0] opcode_len,
    output logic       last_cycle
);

    tstate_t    t_q, t_nxt;
    logic [7:0] ir_q, ir_nxt;
    logic [2:0] ct_q, ct_nxt, ct_upd;
    logic [1:0] len_q, len_nxt;
    logic [2:0] base_cycles;
    logic [1:0] base_len;

    k6502_predecode u_predecode (
        .op          (d),
        .base_cycles (base_cycles),
        .length      (base_len)
    );

    always_ff @(posedge ph0) begin
        if (reset) begin
            t_q   <= T1;
            ir_q  <= IR_RESET;
            ct_q  <= 3'd2;
            len_q <= 2'd1;
        end else begin
            t_q   <= t_nxt;
            ir_q  <= ir_nxt;
            ct_q  <= ct_nxt;
            len_q <= len_nxt;
        end
    end

    always_comb begin
        t_nxt   = t_q;
        ir_nxt  = ir_q;
        ct_nxt  = ct_q;
        len_nxt = len_q;
        // Inserted cycle saturates at 7; the end-of-instruction test uses the
        // updated count so a request on the last cycle extends it.
        ct_upd  = (extra_cycle && (ct_q < MAX_CYC)) ? ct_q + 3'd1 : ct_q;
        if (rdy) begin
            if (t_q == T1) begin
                ir_nxt  = d;
                ct_nxt  = base_cycles;
                len_nxt = base_len;
                t_nxt   = T2;
            end else begin
                ct_nxt = ct_upd;
                t_nxt  = (t_q == ct_upd) ? T1 : t_q + 3'd1;
            end
        end
    end

    assign ir           = ir_q;
    assign t_state      = t_q;
    assign cycles_total = ct_q;
    assign opcode_len   = len_q;
    assign sync         = (t_q == T1);
    assign last_cycle   = (t_q == ct_q) && (t_q != T1);

endmodule

// File: tb/tb_k6502_timing.sv
// Scoreboard bench for k6502_timing: stimulus pushes the hand-computed
// register state expected after each clock; the monitor pops and compares.
module tb_k6502_timing;

    typedef struct packed {
        logic [2:0] t;
        logic [7:0] ir;
        logic [2:0] ct;
        logic [1:0] len;
        logic       sy;
        logic       la;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] d = 8'hFF;
    logic       rdy = 1'b1;
    logic       extra_cycle = 1'b0;
    logic [7:0] ir;
    logic [2:0] t_state;
    logic       sync;
    logic [2:0] cycles_total;
    logic [1:0] opcode_len;
    logic       last_cycle;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  e_mon, a_mon;
    string n_mon;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    k6502_timing #(.IR_RESET(8'h00)) dut (
        .ph0          (clk),
        .reset        (reset),
        .d            (d),
        .rdy          (rdy),
        .extra_cycle  (extra_cycle),
        .ir           (ir),
        .t_state      (t_state),
        .sync         (sync),
        .cycles_total (cycles_total),
        .opcode_len   (opcode_len),
        .last_cycle   (last_cycle)
    );

    // Monitor: registered outputs are sampled 1 time unit after each edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            n_mon = name_q.pop_front();
            a_mon = '{t_state, ir, cycles_total, opcode_len, sync, last_cycle};
            checks++;
            if (a_mon !== e_mon) begin
                errors++;
                $display("FAIL %s: got t=%0d ir=%h ct=%0d len=%0d sync=%b last=%b, expected t=%0d ir=%h ct=%0d len=%0d sync=%b last=%b",
                         n_mon, a_mon.t, a_mon.ir, a_mon.ct, a_mon.len, a_mon.sy, a_mon.la,
                         e_mon.t, e_mon.ir, e_mon.ct, e_mon.len, e_mon.sy, e_mon.la);
            end
        end
    end

    // Apply inputs for one clock and queue the state expected after that edge.
    task automatic step(input string nm, input logic r, input logic rd, input logic [7:0] dv,
                        input logic ex, input logic [2:0] t, input logic [7:0] irv,
                        input logic [2:0] ct, input logic [1:0] ln, input logic sy,
                        input logic la);
        @(negedge clk);
        reset       = r;
        rdy         = rd;
        d           = dv;
        extra_cycle = ex;
        exp_q.push_back('{t, irv, ct, ln, sy, la});
        name_q.push_back(nm);
    endtask

    // Plain instruction with no inserted cycles; base and length hand-supplied.
    task automatic run_insn(input string nm, input logic [7:0] op, input logic [2:0] base,
                            input logic [1:0] ln);
        step(nm, 0, 1, op, 0, 3'd2, op, base, ln, 0, (base == 3'd2));
        for (int tt = 3; tt <= int'(base); tt++)
            step(nm, 0, 1, 8'hEA, 0, 3'(tt), op, base, ln, 0, (tt == int'(base)));
        step(nm, 0, 1, 8'hEA, 0, 3'd1, op, base, ln, 1, 0);
    endtask

    initial begin
        // Reset held two clocks with ones on the bus
        step("reset0", 1, 1, 8'hFF, 0, 1, 8'h00, 2, 1, 1, 0);
        step("reset1", 1, 1, 8'hFF, 0, 1, 8'h00, 2, 1, 1, 0);

        // LDA #imm
        step("lda_imm_t2", 0, 1, 8'hA9, 0, 2, 8'hA9, 2, 2, 0, 1);
        step("lda_imm_t1", 0, 1, 8'hEA, 0, 1, 8'hA9, 2, 2, 1, 0);

        // LDA abs,X, no page cross
        run_insn("lda_absx", 8'hBD, 3'd4, 2'd3);

        // LDA abs,X with page cross requested at T4
        step("ldax_x_t2", 0, 1, 8'hBD, 0, 2, 8'hBD, 4, 3, 0, 0);
        step("ldax_x_t3", 0, 1, 8'hEA, 0, 3, 8'hBD, 4, 3, 0, 0);
        step("ldax_x_t4", 0, 1, 8'hEA, 0, 4, 8'hBD, 4, 3, 0, 1);
        step("ldax_x_t5", 0, 1, 8'hEA, 1, 5, 8'hBD, 5, 3, 0, 1);
        step("ldax_x_t1", 0, 1, 8'hEA, 0, 1, 8'hBD, 5, 3, 1, 0);

        // BNE taken with page cross
        step("bne_t2", 0, 1, 8'hD0, 0, 2, 8'hD0, 2, 2, 0, 1);
        step("bne_t3", 0, 1, 8'hEA, 1, 3, 8'hD0, 3, 2, 0, 1);
        step("bne_t4", 0, 1, 8'hEA, 1, 4, 8'hD0, 4, 2, 0, 1);
        step("bne_t1", 0, 1, 8'hEA, 0, 1, 8'hD0, 4, 2, 1, 0);

        // BRK, extra_cycle at T1 ignored and saturated at T7
        step("brk_t2", 0, 1, 8'h00, 1, 2, 8'h00, 7, 2, 0, 0);
        step("brk_t3", 0, 1, 8'hEA, 0, 3, 8'h00, 7, 2, 0, 0);
        step("brk_t4", 0, 1, 8'hEA, 0, 4, 8'h00, 7, 2, 0, 0);
        step("brk_t5", 0, 1, 8'hEA, 0, 5, 8'h00, 7, 2, 0, 0);
        step("brk_t6", 0, 1, 8'hEA, 0, 6, 8'h00, 7, 2, 0, 0);
        step("brk_t7", 0, 1, 8'hEA, 0, 7, 8'h00, 7, 2, 0, 1);
        step("brk_sat", 0, 1, 8'hEA, 1, 1, 8'h00, 7, 2, 1, 0);

        // JSR with a 3-clock rdy stall at T3 while extra_cycle pulses
        step("jsr_t2", 0, 1, 8'h20, 0, 2, 8'h20, 6, 3, 0, 0);
        step("jsr_t3", 0, 1, 8'hEA, 0, 3, 8'h20, 6, 3, 0, 0);
        step("jsr_stall0", 0, 0, 8'hEA, 1, 3, 8'h20, 6, 3, 0, 0);
        step("jsr_stall1", 0, 0, 8'hEA, 0, 3, 8'h20, 6, 3, 0, 0);
        step("jsr_stall2", 0, 0, 8'hEA, 1, 3, 8'h20, 6, 3, 0, 0);
        step("jsr_t4", 0, 1, 8'hEA, 0, 4, 8'h20, 6, 3, 0, 0);
        step("jsr_t5", 0, 1, 8'hEA, 0, 5, 8'h20, 6, 3, 0, 0);
        step("jsr_t6", 0, 1, 8'hEA, 0, 6, 8'h20, 6, 3, 0, 1);
        step("jsr_t1", 0, 1, 8'hEA, 0, 1, 8'h20, 6, 3, 1, 0);

        // Stall at T1: opcode on the bus must not be captured
        step("t1_stall", 0, 0, 8'hA9, 1, 1, 8'h20, 6, 3, 1, 0);

        // ASL abs, reset at T4 (with rdy low, reset still wins)
        step("asl_t2", 0, 1, 8'h0E, 0, 2, 8'h0E, 6, 3, 0, 0);
        step("asl_t3", 0, 1, 8'hEA, 0, 3, 8'h0E, 6, 3, 0, 0);
        step("asl_t4", 0, 1, 8'hEA, 0, 4, 8'h0E, 6, 3, 0, 0);
        step("asl_rst", 1, 0, 8'hEA, 1, 1, 8'h00, 2, 1, 1, 0);
        step("post_rst_t2", 0, 1, 8'hA9, 0, 2, 8'hA9, 2, 2, 0, 1);
        step("post_rst_t1", 0, 1, 8'hEA, 0, 1, 8'hA9, 2, 2, 1, 0);

        // Classification across the opcode map
        run_insn("rts",      8'h60, 3'd6, 2'd1);
        run_insn("rti",      8'h40, 3'd6, 2'd1);
        run_insn("pha",      8'h48, 3'd3, 2'd1);
        run_insn("pla",      8'h68, 3'd4, 2'd1);
        run_insn("inc_zp",   8'hE6, 3'd5, 2'd2);
        run_insn("sta_absx", 8'h9D, 3'd5, 2'd3);
        run_insn("lda_indy", 8'hB1, 3'd5, 2'd2);
        run_insn("sta_indy", 8'h91, 3'd6, 2'd2);
        run_insn("lda_indx", 8'hA1, 3'd6, 2'd2);
        run_insn("lda_zpx",  8'hB5, 3'd4, 2'd2);
        run_insn("jmp_ind",  8'h6C, 3'd5, 2'd3);
        run_insn("jmp_abs",  8'h4C, 3'd3, 2'd3);
        run_insn("inc_absx", 8'hFE, 3'd7, 2'd3);
        run_insn("asl_acc",  8'h0A, 3'd2, 2'd1);
        run_insn("bit_zp",   8'h24, 3'd3, 2'd2);
        run_insn("undef_02", 8'h02, 3'd2, 2'd1);
        run_insn("undef_89", 8'h89, 3'd2, 2'd1);

        // Bounded drain of the scoreboard
        for (int w = 0; w < 10 && exp_q.size() > 0; w++)
            @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/k6502_timing.md
# k6502_timing

Instruction register, predecode and cycle-timing generator for the k6502 core. It sits directly downstream of the pre-decode data latch and consumes each opcode byte fetched from `d`. It classifies the opcode into base cycle count and instruction length, then steps a T-state counter through the instruction, stretching it when the datapath requests extra cycles. Its outputs (`ir`, `t_state`, `sync`, `last_cycle`) drive the random-control decoder that generates `control_signals_t`.

## Interface
Parameters:
- `IR_RESET`, 8'h00, value loaded into `ir` on reset.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `ph0`  input  1  core clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `d`  input  8  data bus; holds the opcode byte during T1.
- `rdy`  input  1  cycle enable; when low, all state holds.
- `extra_cycle`  input  1  datapath request to insert one cycle (page cross or branch taken); sampled only when `rdy`=1.
- `ir`  output  8  instruction register.
- `t_state`  output  3  current cycle, 1..7. T1 is the opcode fetch.
- `sync`  output  1  high exactly when `t_state`==1.
- `cycles_total`  output  3  cycles for the current instruction: base plus inserted cycles, 2..7.
- `opcode_len`  output  2  instruction byte count, 1..3.
- `last_cycle`  output  1  `t_state`==`cycles_total` and `t_state`!=1.

## Operation
- Reset values: `ir`=`IR_RESET`, `t_state`=1, `sync`=1, `cycles_total`=2, `opcode_len`=1, `last_cycle`=0.
- T1 with `rdy`:
  - `ir`<=`d`.
  - `cycles_total`<=base(`d`), `opcode_len`<=len(`d`).
  - `t_state`<=2.
- Tn (n>=2) with `rdy`:
  - If `extra_cycle` and `cycles_total`<7, then `cycles_total`+=1. At 7, saturate and ignore the request.
  - If `t_state` equals the updated `cycles_total`, next state is `t_state`<=1. Otherwise `t_state`+=1.
- `extra_cycle` during T1 is ignored.
- `extra_cycle` on the last cycle extends the instruction: the next state is T(n+1), not T1.
- `rdy`=0: every register holds, `extra_cycle` is ignored, and outputs are stable.
- `reset` overrides `rdy` and aborts any instruction in progress.
- Base cycle counts:
  - 2: implied, accumulator, immediate, relative branch (undefined opcodes decode as 2-cycle, 1-byte NOP).
  - 3: zp, JMP abs, PHA, PHP.
  - 4: zp,X/Y; abs; abs,X/Y read; PLA, PLP.
  - 5: (ind),Y read; abs,X/Y store; zp RMW; JMP ind.
  - 6: (ind,X); (ind),Y store; zp,X RMW; abs RMW; JSR, RTS, RTI.
  - 7: abs,X RMW; BRK.
- Only abs,X/Y reads, (ind),Y reads and branches legitimately receive `extra_cycle`. The block does not police this.
- Length:
  - 1: implied, accumulator, stack ops, RTS, RTI.
  - 2: immediate, zp forms, (ind,X), (ind),Y, branches, BRK.
  - 3: abs forms, JMP, JSR.

## Timing
- `ir`, `cycles_total` and `opcode_len` are valid from the cycle after T1 (T2) through the end of the instruction.
- Latency from opcode on `d` to `ir` valid is 1 clock.
- All outputs are registered or decoded from registers only. There is no combinational path from `d`, `rdy` or `extra_cycle` to any output.
- Back-to-back instructions: T1 immediately follows the last cycle, so there are no bubbles.

## Structure
- Package `k6502_pkg` holds:
  - the `T1` constant and the 3-bit t-state type;
  - the addressing-mode enum (implied, acc, imm, zp, zpx, abs, absx, indx, indy, rel, ind, stack);
  - the `predecode` function, which maps an opcode to {mode, rmw, store, base cycles, length}.
- One sub-module, `k6502_predecode`: a combinational opcode classifier (wraps the package function). The timing FSM stays in `k6502_timing`.

## Test plan
- Reset: hold `reset` for 2 clocks with `d`=8'hFF -> `t_state`=1, `sync`=1, `ir`=8'h00, `cycles_total`=2.
- LDA #imm: `d`=8'hA9 at T1 -> next cycle `ir`=8'hA9, `t_state`=2, `cycles_total`=2, `opcode_len`=2, `last_cycle`=1; following cycle `t_state`=1, `sync`=1.
- LDA abs,X: `d`=8'hBD. Without `extra_cycle` -> T1..T4 then T1. With `extra_cycle` at T4 -> T5 occurs, `cycles_total`=5, then T1.
- BNE taken with page cross: `d`=8'hD0, `extra_cycle` at T2 and T3 -> T1..T4 then T1, `cycles_total`=4. A further request at T4 with `cycles_total` at 7 is not reached here; a separate check with BRK 8'h00 plus `extra_cycle` at T7 -> saturates, next is T1.
- RDY stall: JSR 8'h20, `rdy`=0 for 3 clocks at T3 while pulsing `extra_cycle` -> `t_state` holds 3, `ir` holds 8'h20, `cycles_total` stays 6; then T4..T6, T1.
- Reset mid-instruction: ASL abs 8'h0E, assert `reset` at T4 -> next cycle `t_state`=1, `ir`=8'h00, `cycles_total`=2; a new opcode is accepted normally afterwards.
